// File: rtl/frac_n_divider.sv
// Fractional-N clock divider controller: divides clk by a per-period integer N
// dithered by a first-order accumulator so that the mean N tracks ratio/16.
module frac_n_divider #(
  parameter int IW    = 4,
  parameter int FW    = 4,
  parameter int NMIN  = 2,
  parameter int N_RST = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [IW+FW-1:0]     ratio,
  output logic [IW-1:0]        n,
  output logic                 div_pulse,
  output logic                 div_clk,
  output logic                 ratio_err
);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT} state_t;

  localparam logic [IW:0] NMIN_W = NMIN[IW:0];
  localparam logic [IW:0] NMAX_W = {1'b0, {IW{1'b1}}};

  state_t          state_reg, state_next;
  logic [IW-1:0]   cnt_reg, cnt_next;
  logic [IW-1:0]   n_reg, n_next;
  logic [FW-1:0]   acc_reg, acc_next;
  logic            err_reg, err_next;

  logic [FW:0]     sum;
  logic [IW:0]     n_raw;
  logic [IW-1:0]   n_load;
  logic            err_load;

  // Accumulator carry bumps the integer part; result clamped to the legal range.
  always_comb begin
    sum   = {1'b0, acc_reg} + {1'b0, ratio[FW-1:0]};
    n_raw = {1'b0, ratio[IW+FW-1:FW]} + {{IW{1'b0}}, sum[FW]};
    if (n_raw < NMIN_W) begin
      n_load   = NMIN_W[IW-1:0];
      err_load = 1'b1;
    end else if (n_raw > NMAX_W) begin
      n_load   = NMAX_W[IW-1:0];
      err_load = 1'b1;
    end else begin
      n_load   = n_raw[IW-1:0];
      err_load = 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    n_next     = n_reg;
    acc_next   = acc_reg;
    err_next   = err_reg;
    if (!en) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE:  state_next = LOAD;
        LOAD:  state_next = COUNT;
        COUNT: begin
          if (cnt_reg == IW'(1)) state_next = LOAD;
          else                   cnt_next   = cnt_reg - IW'(1);
        end
        default: state_next = IDLE;
      endcase
      // Every transition into LOAD commits the next period's divide value.
      if (state_next == LOAD) begin
        acc_next = sum[FW-1:0];
        n_next   = n_load;
        err_next = err_load;
        cnt_next = n_load - IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      n_reg     <= N_RST[IW-1:0];
      acc_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      n_reg     <= n_next;
      acc_reg   <= acc_next;
      err_reg   <= err_next;
    end
  end

  // LOAD holds cnt at N-1 and COUNT walks N-1..1, so cycle k of COUNT has cnt=N-k;
  // high while k < ceil(N/2), i.e. cnt > floor(N/2).
  assign div_pulse = (state_reg == LOAD);
  assign div_clk   = (state_reg == LOAD) ||
                     ((state_reg == COUNT) && (cnt_reg > (n_reg >> 1)));
  assign n         = n_reg;
  assign ratio_err = err_reg;

endmodule

// File: tb/tb_frac_n_divider.sv
// Directed bench for frac_n_divider: reset, integer/fractional ratios, clamping, controls.
module tb_frac_n_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] ratio;
  logic [3:0] n;
  logic       div_pulse;
  logic       div_clk;
  logic       ratio_err;

  int n_checks = 0;
  int n_fail   = 0;

  int         per_len[16];
  logic [3:0] per_n[16];
  logic       per_err[16];
  bit         per_timeout;

  frac_n_divider dut (
    .clk(clk), .rst(rst), .en(en), .ratio(ratio),
    .n(n), .div_pulse(div_pulse), .div_clk(div_clk), .ratio_err(ratio_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    en  = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Starting on a LOAD cycle, records n/ratio_err and length of np periods.
  task automatic run_periods(input int np);
    int len;
    per_timeout = 1'b0;
    for (int p = 0; p < np; p++) begin
      per_n[p]   = n;
      per_err[p] = ratio_err;
      len = 0;
      do begin
        step();
        len++;
      end while (!div_pulse && len < 40);
      if (!div_pulse) per_timeout = 1'b1;
      per_len[p] = len;
    end
  endtask

  task automatic capture(input int nc, output logic [31:0] pv, output logic [31:0] cv);
    pv = '0;
    cv = '0;
    for (int i = 0; i < nc; i++) begin
      pv[i] = div_pulse;
      cv[i] = div_clk;
      step();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; ratio = 8'h00;
    #2;
    n_checks++; if (n !== 4'd3) begin n_fail++; $display("FAIL reset_n: got %0d expected 3", n); end
    n_checks++; if (div_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b expected 0", div_pulse); end
    n_checks++; if (div_clk !== 1'b0) begin n_fail++; $display("FAIL reset_clk: got %b expected 0", div_clk); end
    n_checks++; if (ratio_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", ratio_err); end
    step();
    rst = 1'b0; ratio = 8'h10; en = 1'b1;
    step();
    n_checks++; if (n !== 4'd2 || ratio_err !== 1'b1) begin n_fail++; $display("FAIL pre_reset_load: got n=%0d err=%b expected n=2 err=1", n, ratio_err); end
    step();
    step();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (n !== 4'd3) begin n_fail++; $display("FAIL async_reset_n: got %0d expected 3", n); end
    n_checks++; if (div_pulse !== 1'b0) begin n_fail++; $display("FAIL async_reset_pulse: got %b expected 0", div_pulse); end
    n_checks++; if (div_clk !== 1'b0) begin n_fail++; $display("FAIL async_reset_clk: got %b expected 0", div_clk); end
    n_checks++; if (ratio_err !== 1'b0) begin n_fail++; $display("FAIL async_reset_err: got %b expected 0", ratio_err); end
    en = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (n !== 4'd3 || div_pulse !== 1'b0 || div_clk !== 1'b0 || ratio_err !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold: got n=%0d pulse=%b clk=%b err=%b expected 3/0/0/0", n, div_pulse, div_clk, ratio_err);
      end
    end
  endtask

  task automatic test_integer;
    logic [31:0] pv, cv;
    do_reset();
    ratio = 8'h40; en = 1'b1;
    step();
    n_checks++; if (n !== 4'd4 || ratio_err !== 1'b0) begin n_fail++; $display("FAIL int4_n: got n=%0d err=%b expected 4/0", n, ratio_err); end
    capture(12, pv, cv);
    n_checks++; if (pv !== 32'h111) begin n_fail++; $display("FAIL int4_pulse: got %h expected 111", pv); end
    n_checks++; if (cv !== 32'h333) begin n_fail++; $display("FAIL int4_clk: got %h expected 333", cv); end
    do_reset();
    ratio = 8'h50; en = 1'b1;
    step();
    n_checks++; if (n !== 4'd5) begin n_fail++; $display("FAIL int5_n: got %0d expected 5", n); end
    capture(15, pv, cv);
    n_checks++; if (pv !== 32'h421) begin n_fail++; $display("FAIL int5_pulse: got %h expected 421", pv); end
    n_checks++; if (cv !== 32'h1ce7) begin n_fail++; $display("FAIL int5_clk: got %h expected 1ce7", cv); end
  endtask

  task automatic test_half;
    int total = 0;
    do_reset();
    ratio = 8'h48; en = 1'b1;
    step();
    run_periods(16);
    n_checks++; if (per_timeout) begin n_fail++; $display("FAIL half_timeout: got timeout expected pulses"); end
    for (int p = 0; p < 16; p++) begin
      total += per_len[p];
      n_checks++;
      if (per_n[p] !== ((p % 2 == 1) ? 4'd5 : 4'd4) || per_len[p] != ((p % 2 == 1) ? 5 : 4)) begin
        n_fail++;
        $display("FAIL half_period%0d: got n=%0d len=%0d expected %0d", p, per_n[p], per_len[p], (p % 2 == 1) ? 5 : 4);
      end
    end
    n_checks++; if (total != 72) begin n_fail++; $display("FAIL half_total: got %0d expected 72", total); end
  endtask

  task automatic test_small;
    int total = 0;
    int nsum = 0;
    do_reset();
    ratio = 8'h31; en = 1'b1;
    step();
    run_periods(16);
    n_checks++; if (per_timeout) begin n_fail++; $display("FAIL small_timeout: got timeout expected pulses"); end
    for (int p = 0; p < 16; p++) begin
      total += per_len[p];
      nsum  += int'(per_n[p]);
      n_checks++;
      if (per_n[p] !== ((p == 15) ? 4'd4 : 4'd3) || per_len[p] != ((p == 15) ? 4 : 3)) begin
        n_fail++;
        $display("FAIL small_period%0d: got n=%0d len=%0d expected %0d", p, per_n[p], per_len[p], (p == 15) ? 4 : 3);
      end
    end
    n_checks++; if (total != 49) begin n_fail++; $display("FAIL small_total: got %0d expected 49", total); end
    n_checks++; if (nsum != 49) begin n_fail++; $display("FAIL small_nsum: got %0d expected 49", nsum); end
  endtask

  task automatic test_clamp;
    do_reset();
    ratio = 8'h10; en = 1'b1;
    step();
    run_periods(4);
    n_checks++; if (per_timeout) begin n_fail++; $display("FAIL clamp_lo_timeout: got timeout expected pulses"); end
    for (int p = 0; p < 4; p++) begin
      n_checks++;
      if (per_n[p] !== 4'd2 || per_len[p] != 2 || per_err[p] !== 1'b1) begin
        n_fail++;
        $display("FAIL clamp_lo%0d: got n=%0d len=%0d err=%b expected 2/2/1", p, per_n[p], per_len[p], per_err[p]);
      end
    end
    do_reset();
    ratio = 8'hF8; en = 1'b1;
    step();
    run_periods(4);
    n_checks++; if (per_timeout) begin n_fail++; $display("FAIL clamp_hi_timeout: got timeout expected pulses"); end
    for (int p = 0; p < 4; p++) begin
      n_checks++;
      if (per_n[p] !== 4'd15 || per_len[p] != 15 || per_err[p] !== ((p % 2 == 1) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL clamp_hi%0d: got n=%0d len=%0d err=%b expected 15/15/%0d", p, per_n[p], per_len[p], per_err[p], p % 2);
      end
    end
  endtask

  task automatic test_controls;
    int len;
    do_reset();
    ratio = 8'h40; en = 1'b1;
    step();
    n_checks++; if (div_pulse !== 1'b1 || n !== 4'd4) begin n_fail++; $display("FAIL ctl_first: got pulse=%b n=%0d expected 1/4", div_pulse, n); end
    step();
    ratio = 8'h60;
    len = 1;
    do begin
      step();
      len++;
    end while (!div_pulse && len < 40);
    n_checks++; if (len != 4) begin n_fail++; $display("FAIL ctl_midchange_len: got %0d expected 4", len); end
    n_checks++; if (n !== 4'd6) begin n_fail++; $display("FAIL ctl_new_n: got %0d expected 6", n); end
    run_periods(1);
    n_checks++; if (per_len[0] != 6) begin n_fail++; $display("FAIL ctl_new_len: got %0d expected 6", per_len[0]); end
    for (int i = 0; i < 4; i++) step();
    en = 1'b0;
    step();
    n_checks++; if (div_pulse !== 1'b0 || div_clk !== 1'b0 || n !== 4'd6) begin n_fail++; $display("FAIL ctl_disable: got pulse=%b clk=%b n=%0d expected 0/0/6", div_pulse, div_clk, n); end
    step();
    step();
    n_checks++; if (div_pulse !== 1'b0 || n !== 4'd6) begin n_fail++; $display("FAIL ctl_idle_hold: got pulse=%b n=%0d expected 0/6", div_pulse, n); end
    en = 1'b1;
    step();
    n_checks++; if (div_pulse !== 1'b1 || n !== 4'd6) begin n_fail++; $display("FAIL ctl_reenable: got pulse=%b n=%0d expected 1/6", div_pulse, n); end
    run_periods(1);
    n_checks++; if (per_len[0] != 6 || per_timeout) begin n_fail++; $display("FAIL ctl_reenable_len: got %0d expected 6", per_len[0]); end
  endtask

  initial begin
    test_reset();
    test_integer();
    test_half();
    test_small();
    test_clamp();
    test_controls();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
